// File: rtl/gated_pulse_counter_pkg.sv
// gated_pulse_counter_pkg
//   Shared definitions for the gated pulse counter:
//     - gate FSM state encoding (IDLE=1'b0, RUN=1'b1)
//     - default gate length, accumulator width and dead time
//     - a width helper for the internal counters
//   No ports (package).

package gated_pulse_counter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } gate_state_e;

    localparam int unsigned GATE_TICKS_DEF = 4000;
    localparam int unsigned CNT_W_DEF      = 16;
    localparam int unsigned DEAD_TICKS_DEF = 8;

    // Bits needed to hold values 0..max_val (never less than 1).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((max_val >> w) != 0)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/gated_pulse_counter_sync.sv
// pulse_sync_edge
//   Brings an asynchronous detector pulse into the clk_in domain through a
//   three-flop chain (s1 -> s2 -> s3) and flags its rising edge with a
//   registered one-cycle strobe. A level first sampled into s1 at edge k
//   produces edge_out high during the cycle after edge k+2.
// Ports
//   clk_in    in   1  system clock
//   reset     in   1  synchronous reset, active high
//   async_in  in   1  asynchronous input level
//   edge_out  out  1  one-cycle rising-edge strobe

module pulse_sync_edge (
    input  logic clk_in,
    input  logic reset,
    input  logic async_in,
    output logic edge_out
);

    logic s1_q, s2_q, s3_q;
    logic edge_q, edge_d;

    always_comb begin
        edge_d = s2_q & ~s3_q;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            s1_q   <= async_in;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            edge_q <= edge_d;
        end
    end

    assign edge_out = edge_q;

endmodule

// File: rtl/gated_pulse_counter.sv
// gated_pulse_counter
//   Counts detector pulse rising edges over back-to-back gate windows of
//   GATE_TICKS clk_in cycles while enable is high. Each completed gate result
//   is latched into count_out and offered to the reader with count_valid /
//   count_ack. The accumulator saturates at 2^CNT_W-1 and the saturation is
//   reported through overflow. A result replaced before it was acked raises
//   missed.
//   Optional feature macro: PULSE_DEADTIME_EN -- when defined, an accepted
//   edge blocks further edges for DEAD_TICKS cycles.
// Ports
//   clk_in       in   1      4 MHz system clock
//   reset        in   1      synchronous reset, active high
//   pulse_in     in   1      asynchronous detector pulse
//   enable       in   1      run gates while high
//   count_out    out  CNT_W  count from the last completed gate
//   count_valid  out  1      count_out holds an unread result
//   count_ack    in   1      reader consumed the result
//   overflow     out  1      the latched gate saturated
//   missed       out  1      a result was overwritten before it was acked

module gated_pulse_counter
    import gated_pulse_counter_pkg::*;
#(
    parameter int unsigned GATE_TICKS = GATE_TICKS_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned DEAD_TICKS = DEAD_TICKS_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic             enable,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    input  logic             count_ack,
    output logic             overflow,
    output logic             missed
);

    localparam int unsigned GW = cnt_width(GATE_TICKS - 1);

    gate_state_e      state_q, state_d;
    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] count_out_q, count_out_d;
    logic             count_valid_q, count_valid_d;
    logic             overflow_q, overflow_d;
    logic             missed_q, missed_d;

    logic             edge_s;
    logic             running;
    logic             dead_ok;
    logic             accept;
    logic             sat_now;
    logic [CNT_W-1:0] acc_next;
    logic             gate_end;

    pulse_sync_edge u_sync (
        .clk_in   (clk_in),
        .reset    (reset),
        .async_in (pulse_in),
        .edge_out (edge_s)
    );

    assign running = (state_q == ST_RUN) && enable;
    assign accept  = edge_s && running && dead_ok;

`ifdef PULSE_DEADTIME_EN
    localparam int unsigned DW = cnt_width(DEAD_TICKS);

    logic [DW-1:0] dead_cnt_q, dead_cnt_d;

    always_comb begin
        dead_cnt_d = dead_cnt_q;
        if (state_q == ST_IDLE) begin
            dead_cnt_d = '0;
        end else if (accept) begin
            dead_cnt_d = DW'(DEAD_TICKS);
        end else if (dead_cnt_q != '0) begin
            dead_cnt_d = dead_cnt_q - DW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            dead_cnt_q <= '0;
        end else begin
            dead_cnt_q <= dead_cnt_d;
        end
    end

    assign dead_ok = (dead_cnt_q == '0);
`else
    // Dead time not built; parameter kept for interface compatibility.
    logic unused_dead_ticks;
    assign unused_dead_ticks = ^DEAD_TICKS;
    assign dead_ok           = 1'b1;
`endif

    // Saturating accumulate; sat_now marks an edge lost to saturation.
    always_comb begin
        sat_now  = accept && (acc_q == '1);
        acc_next = acc_q;
        if (accept && !sat_now) begin
            acc_next = acc_q + CNT_W'(1);
        end
    end

    assign gate_end = running && (gate_cnt_q == GW'(GATE_TICKS - 1));

    always_comb begin
        state_d       = state_q;
        gate_cnt_d    = gate_cnt_q;
        acc_d         = acc_q;
        sat_d         = sat_q;
        count_out_d   = count_out_q;
        count_valid_d = count_valid_q;
        overflow_d    = overflow_q;
        missed_d      = missed_q;

        // Reader handshake; a gate end below in the same cycle overrides it.
        if (count_ack && count_valid_q) begin
            count_valid_d = 1'b0;
            missed_d      = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                gate_cnt_d = '0;
                acc_d      = '0;
                sat_d      = 1'b0;
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    // Abort: partial gate discarded, latched result untouched.
                    state_d    = ST_IDLE;
                    gate_cnt_d = '0;
                    acc_d      = '0;
                    sat_d      = 1'b0;
                end else if (gate_end) begin
                    count_out_d   = acc_next;
                    overflow_d    = sat_q | sat_now;
                    count_valid_d = 1'b1;
                    if (count_valid_q && !count_ack) begin
                        missed_d = 1'b1;
                    end
                    gate_cnt_d = '0;
                    acc_d      = '0;
                    sat_d      = 1'b0;
                end else begin
                    gate_cnt_d = gate_cnt_q + GW'(1);
                    acc_d      = acc_next;
                    sat_d      = sat_q | sat_now;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            gate_cnt_q    <= '0;
            acc_q         <= '0;
            sat_q         <= 1'b0;
            count_out_q   <= '0;
            count_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
            missed_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            gate_cnt_q    <= gate_cnt_d;
            acc_q         <= acc_d;
            sat_q         <= sat_d;
            count_out_q   <= count_out_d;
            count_valid_q <= count_valid_d;
            overflow_q    <= overflow_d;
            missed_q      <= missed_d;
        end
    end

    assign count_out   = count_out_q;
    assign count_valid = count_valid_q;
    assign overflow    = overflow_q;
    assign missed      = missed_q;

endmodule

// File: tb/tb_gated_pulse_counter.sv
// tb_gated_pulse_counter
//   Drives two counters from the same inputs: the main one (CNT_W=8) and a
//   narrow one (CNT_W=4) whose small range makes saturation reachable within
//   a 100-tick gate. Both are compared every cycle against a behavioural
//   model, with directed scenario checks against fixed expected values.

`timescale 1ns/1ps

module tb_gated_pulse_counter;

    localparam int GT = 100;
    localparam int DT = 4;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       pulse_in;
    logic       enable;
    logic       count_ack;

    logic [7:0] cnt_a;
    logic       valid_a, ovf_a, miss_a;
    logic [3:0] cnt_b;
    logic       valid_b, ovf_b, miss_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #125 clk_in = ~clk_in;

    gated_pulse_counter #(
        .GATE_TICKS (GT),
        .CNT_W      (8),
        .DEAD_TICKS (DT)
    ) u_dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .pulse_in    (pulse_in),
        .enable      (enable),
        .count_out   (cnt_a),
        .count_valid (valid_a),
        .count_ack   (count_ack),
        .overflow    (ovf_a),
        .missed      (miss_a)
    );

    gated_pulse_counter #(
        .GATE_TICKS (GT),
        .CNT_W      (4),
        .DEAD_TICKS (DT)
    ) u_dut_narrow (
        .clk_in      (clk_in),
        .reset       (reset),
        .pulse_in    (pulse_in),
        .enable      (enable),
        .count_out   (cnt_b),
        .count_valid (valid_b),
        .count_ack   (count_ack),
        .overflow    (ovf_b),
        .missed      (miss_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference: unbounded count per gate, clamped at latch time.
    typedef struct {
        bit run;
        int pos;
        int count;
        int last;
        int oc;
        bit v;
        bit oo;
        bit om;
    } mdl_t;

    mdl_t m[2];
    bit   hist[4];
    int   cyc = 0;
    bit   chk_on = 0;

    task automatic model_step(input int i, input bit ev, input int maxv);
        bit old_v;
        bit acc;
        if (reset) begin
            m[i].run = 0; m[i].pos = 0; m[i].count = 0; m[i].last = -1000;
            m[i].oc = 0; m[i].v = 0; m[i].oo = 0; m[i].om = 0;
            return;
        end
        old_v = m[i].v;
        if (count_ack && m[i].v) begin
            m[i].v  = 0;
            m[i].om = 0;
        end
        if (!m[i].run) begin
            if (enable) begin
                m[i].run = 1; m[i].pos = 0; m[i].count = 0; m[i].last = -1000;
            end
        end else if (!enable) begin
            m[i].run = 0;
        end else begin
            acc = ev;
`ifdef PULSE_DEADTIME_EN
            if (cyc - m[i].last <= DT) acc = 0;
`endif
            if (acc) begin
                m[i].count++;
                m[i].last = cyc;
            end
            if (m[i].pos == GT - 1) begin
                m[i].oc = (m[i].count > maxv) ? maxv : m[i].count;
                m[i].oo = (m[i].count > maxv);
                if (old_v && !count_ack) m[i].om = 1;
                m[i].v     = 1;
                m[i].count = 0;
                m[i].pos   = 0;
            end else begin
                m[i].pos++;
            end
        end
    endtask

    // The pulse level sampled at edge n-3, with a low at n-4, is counted at edge n.
    always @(posedge clk_in) begin
        bit ev;
        ev = hist[2] & ~hist[3];
        model_step(0, ev, 255);
        model_step(1, ev, 15);
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = reset ? 1'b0 : pulse_in;
        cyc++;
    end

    always @(negedge clk_in) begin
        if (chk_on) begin
            check_eq("m_cnt_a",   32'(cnt_a),   32'(m[0].oc));
            check_eq("m_valid_a", 32'(valid_a), 32'(m[0].v));
            check_eq("m_ovf_a",   32'(ovf_a),   32'(m[0].oo));
            check_eq("m_miss_a",  32'(miss_a),  32'(m[0].om));
            check_eq("m_cnt_b",   32'(cnt_b),   32'(m[1].oc));
            check_eq("m_valid_b", 32'(valid_b), 32'(m[1].v));
            check_eq("m_ovf_b",   32'(ovf_b),   32'(m[1].oo));
            check_eq("m_miss_b",  32'(miss_b),  32'(m[1].om));
        end
    end

    task automatic step(input bit p, input bit e, input bit a);
        pulse_in  = p;
        enable    = e;
        count_ack = a;
        @(negedge clk_in);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0);
    endtask

    // Runs ng back-to-back gates from IDLE; gate 0 carries np0 pulses, later
    // gates np1. Returns at the negedge after the last gate-end edge.
    task automatic run_gates(input int ng, input int np0, input int np1,
                             input int per, input int hi, input int ack_step);
        int g, off, np;
        bit p;
        for (int s = 0; s <= GT * ng; s++) begin
            g   = s / GT;
            off = s % GT;
            np  = (g == 0) ? np0 : np1;
            p   = (s < GT * ng) && (off < np * per) && ((off % per) < hi);
            step(p, 1, s == ack_step);
        end
    endtask

    initial begin
        int exp_dead;
        int last;
        reset     = 1;
        pulse_in  = 0;
        enable    = 0;
        count_ack = 0;
        for (int k = 0; k < 5; k++) step(k[0], 0, 0);
        check_eq("rst_cnt",   32'(cnt_a),   0);
        check_eq("rst_valid", 32'(valid_a), 0);
        check_eq("rst_ovf",   32'(ovf_a),   0);
        check_eq("rst_miss",  32'(miss_a),  0);
        check_eq("rst_cnt_b", 32'(cnt_b),   0);
        reset  = 0;
        chk_on = 1;
        idle(100);
        check_eq("idle_valid", 32'(valid_a), 0);

        // Basic gate: 10 pulses, result after 100 cycles.
        run_gates(1, 10, 0, 10, 3, -1);
        check_eq("basic_cnt",   32'(cnt_a),   10);
        check_eq("basic_valid", 32'(valid_a), 1);
        check_eq("basic_ovf",   32'(ovf_a),   0);
        step(0, 0, 1);
        check_eq("ack_valid", 32'(valid_a), 0);
        check_eq("ack_miss",  32'(miss_a),  0);
        idle(3);

        // Saturation on the narrow instance, then a clean gate.
        run_gates(1, 48, 0, 2, 1, -1);
        check_eq("sat_cnt", 32'(cnt_b), 15);
        check_eq("sat_ovf", 32'(ovf_b), 1);
        step(0, 0, 1);
        idle(2);
        run_gates(1, 5, 0, 10, 3, -1);
        check_eq("post_sat_cnt", 32'(cnt_b), 5);
        check_eq("post_sat_ovf", 32'(ovf_b), 0);
        step(0, 0, 1);
        idle(2);

        // Two gate ends without ack.
        run_gates(2, 3, 6, 10, 3, -1);
        check_eq("miss_set",   32'(miss_a),  1);
        check_eq("miss_cnt",   32'(cnt_a),   6);
        check_eq("miss_valid", 32'(valid_a), 1);
        step(0, 0, 1);
        check_eq("miss_ack_valid", 32'(valid_a), 0);
        check_eq("miss_ack_miss",  32'(miss_a),  0);
        idle(2);

        // Ack on the second gate-end edge.
        run_gates(2, 4, 2, 10, 3, 2 * GT);
        check_eq("ackend_valid", 32'(valid_a), 1);
        check_eq("ackend_miss",  32'(miss_a),  0);
        check_eq("ackend_cnt",   32'(cnt_a),   2);
        step(0, 0, 1);
        idle(2);

        // Abort at gate_cnt=50 after 7 pulses.
        for (int s = 0; s <= 50; s++) step((s < 49) && ((s % 7) < 3), 1, 0);
        idle(5);
        check_eq("abort_valid", 32'(valid_a), 0);
        check_eq("abort_cnt",   32'(cnt_a),   2);
        run_gates(1, 4, 0, 10, 3, -1);
        check_eq("after_abort_cnt", 32'(cnt_a), 4);
        step(0, 0, 1);
        idle(2);

        // Edges two cycles apart.
`ifdef PULSE_DEADTIME_EN
        exp_dead = 0;
        last     = -1000;
        for (int e = 0; e < 20; e++) begin
            if (2 * e - last > DT) begin
                exp_dead++;
                last = 2 * e;
            end
        end
`else
        exp_dead = 20;
        last     = 0;
`endif
        run_gates(1, 20, 0, 2, 1, -1);
        check_eq("dead_cnt", 32'(cnt_a), 32'(exp_dead));
        step(0, 0, 1);
        idle(2);

        // Random traffic: random pulses, rare enable drops, random acks.
        for (int s = 0; s < 1200; s++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 7) == 0));
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
